// File: rtl/cnt_reset_sched.sv
// cnt_reset_sched: round-robin arbiter that pulses the count generator's reset and times its restart.
module cnt_reset_sched #(
  parameter int NUM_REQ = 4,
  parameter int PULSE_LEN = 2,
  parameter int MAX_WAIT = 48,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [31:0]        count_in,
  input  logic               parity_in,
  input  logic               valid_in,
  output logic               cnt_rst,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic               parity_err,
  output logic [31:0]        last_count
);
  typedef enum logic [2:0] {IDLE, PULSE, WAIT, DONE_OK, DONE_TO} state_t;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic found;
  logic [3:0] pcnt;
  logic [7:0] wait_cnt;
  logic [2*NUM_REQ-1:0] dbl;
  // Rotate requests so bit 0 is the RR pointer; lowest set bit wins.
  always_comb begin
    dbl = {req, req} >> ptr;
    pick = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (dbl[i]) begin
        pick = IW'((int'(ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      pcnt <= '0;
      wait_cnt <= '0;
      cnt_rst <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      ack <= '0;
      err <= '0;
      parity_err <= 1'b0;
      last_count <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      if (valid_in) begin
        last_count <= count_in;
        if (parity_in != ^count_in) parity_err <= 1'b1;
      end
      case (state)
        IDLE:
          if (found) begin
            grant_id <= pick;
            ptr <= IW'((int'(pick) + 1) % NUM_REQ);
            state <= PULSE;
            busy <= 1'b1;
            cnt_rst <= 1'b1;
            pcnt <= '0;
          end
        PULSE:
          if (pcnt == 4'(PULSE_LEN - 1)) begin
            cnt_rst <= 1'b0;
            state <= WAIT;
            wait_cnt <= '0;
          end else pcnt <= pcnt + 4'd1;
        WAIT:
          if (valid_in && count_in <= 32'd1) begin
            state <= DONE_OK;
            ack <= NUM_REQ'(1) << grant_id;
          end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            state <= DONE_TO;
            err <= NUM_REQ'(1) << grant_id;
          end else wait_cnt <= (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
        DONE_OK, DONE_TO: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cnt_reset_sched.sv
// tb_cnt_reset_sched: random and directed stimulus checked against an elapsed-time model of the scheduler.
module tb_cnt_reset_sched;
  localparam int N = 4, P = 2, M = 48;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0;
  logic [31:0] count_in = '0;
  logic parity_in = 0, valid_in = 0;
  logic cnt_rst, busy, parity_err;
  logic [1:0] grant_id;
  logic [N-1:0] ack, err;
  logic [31:0] last_count;
  int vectors = 0, miscompares = 0, cyc = 0;

  cnt_reset_sched #(.NUM_REQ(N), .PULSE_LEN(P), .MAX_WAIT(M)) dut (
    .clk(clk), .rst(rst), .req(req), .count_in(count_in), .parity_in(parity_in),
    .valid_in(valid_in), .cnt_rst(cnt_rst), .busy(busy), .grant_id(grant_id),
    .ack(ack), .err(err), .parity_err(parity_err), .last_count(last_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Model: a grant is timed by edges elapsed since it was taken (t=0 at the grant edge).
  bit m_active = 0, m_done = 0, m_f = 0;
  int m_t = 0, m_ptr = 0, m_gid = 0;
  logic [N-1:0] m_ack = '0, m_err = '0;
  logic m_perr = 0;
  logic [31:0] m_last = '0;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_active = 0; m_done = 0; m_t = 0; m_ptr = 0; m_gid = 0;
      m_ack = '0; m_err = '0; m_perr = 0; m_last = '0;
    end else begin
      m_ack = '0;
      m_err = '0;
      if (valid_in) begin
        m_last = count_in;
        if (parity_in !== ^count_in) m_perr = 1;
      end
      if (!m_active) begin
        m_f = 0;
        for (int i = 0; i < N; i++)
          if (!m_f && req[(m_ptr + i) % N]) begin m_f = 1; m_gid = (m_ptr + i) % N; end
        if (m_f) begin m_ptr = (m_gid + 1) % N; m_active = 1; m_done = 0; m_t = 0; end
      end else begin
        m_t++;
        if (m_done) m_active = 0;
        else if (m_t > P && valid_in && count_in <= 1) begin m_ack[m_gid] = 1; m_done = 1; end
        else if (m_t == P + M) begin m_err[m_gid] = 1; m_done = 1; end
      end
    end

  always @(negedge clk) begin
    chk("cnt_rst", cnt_rst, m_active && !m_done && m_t < P);
    chk("busy", busy, m_active);
    chk("grant_id", grant_id, m_gid);
    chk("ack", ack, m_ack);
    chk("err", err, m_err);
    chk("parity_err", parity_err, m_perr);
    chk("last_count", last_count, m_last);
  end

  // Event log for the directed literal checks.
  int pulse_hi, npulse, nack, nerr, ack_cyc, err_cyc, rise_cyc;
  logic [N-1:0] ack_val, err_val;
  logic prev_rst = 0;
  int gq[$], aq[$];

  always @(negedge clk) begin
    if (cnt_rst) pulse_hi++;
    if (cnt_rst && !prev_rst) begin gq.push_back(int'(grant_id)); npulse++; rise_cyc = cyc; end
    prev_rst = cnt_rst;
    if (ack != 0) begin
      ack_cyc = cyc; ack_val = ack; nack++;
      for (int j = 0; j < N; j++) if (ack[j]) aq.push_back(j);
    end
    if (err != 0) begin err_cyc = cyc; err_val = err; nerr++; end
  end

  task automatic clr_logs();
    pulse_hi = 0; npulse = 0; nack = 0; nerr = 0;
    ack_cyc = -1; err_cyc = -1; rise_cyc = -1;
    ack_val = '0; err_val = '0;
    gq.delete(); aq.delete();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0; clr_logs();
  endtask

  int n0, w;
  bit slow;

  initial begin
    clr_logs();
    tick(3);
    chk("reset_state", {cnt_rst, busy, grant_id, ack, err, parity_err, last_count}, 64'd0);
    rst = 0;
    // Single request, generator restarts 10 clocks later
    clr_logs();
    req = 4'b0001; n0 = cyc + 1; tick();
    tick(10);
    valid_in = 1; count_in = 1; parity_in = 1; w = cyc + 1; tick();
    valid_in = 0; req = '0; tick(2);
    chk("single_pulse_len", pulse_hi, 2);
    chk("single_pulse_start", rise_cyc, n0);
    chk("single_ack_cyc", ack_cyc, w);
    chk("single_ack_val", ack_val, 4'b0001);
    chk("single_grant", grant_id, 0);
    chk("single_no_err", nerr, 0);
    // Round robin with all four requesting
    do_reset();
    req = 4'b1111; valid_in = 1; count_in = 1; parity_in = 1;
    for (int k = 0; k < 200 && req != 0; k++) begin tick(); req &= ~ack; end
    valid_in = 0; tick(2);
    chk("rr_all_served", req, 0);
    chk("rr_pulses", npulse, 4);
    chk("rr_ngrant", gq.size(), 4);
    for (int k = 0; k < gq.size(); k++) chk("rr_grant_order", gq[k], k);
    chk("rr_nack", aq.size(), 4);
    for (int k = 0; k < aq.size(); k++) chk("rr_ack_order", aq[k], k);
    // Timeout: beats never carry a count <= 1
    do_reset();
    req = 4'b0100; n0 = cyc + 1;
    for (int k = 0; k < 60; k++) begin
      valid_in = 1'($urandom_range(0, 1));
      count_in = $urandom_range(5, 1000);
      parity_in = ^count_in;
      tick();
      if (err != 0) req = '0;
    end
    valid_in = 0; req = '0; tick(2);
    chk("to_err_cyc", err_cyc, n0 + P + M);
    chk("to_err_val", err_val, 4'b0100);
    chk("to_no_ack", nack, 0);
    // Window boundary: success beat on the last window cycle
    do_reset();
    req = 4'b0001; n0 = cyc + 1; tick();
    tick(49);
    valid_in = 1; count_in = 1; parity_in = 1; tick();
    valid_in = 0; req = '0; tick(2);
    chk("win_ack_cyc", ack_cyc, n0 + P + M);
    chk("win_ack_val", ack_val, 4'b0001);
    chk("win_no_err", nerr, 0);
    // Parity error is sticky until reset
    valid_in = 1; count_in = 3; parity_in = 1; tick();
    valid_in = 0; tick();
    chk("par_err_set", parity_err, 1);
    chk("par_last", last_count, 3);
    valid_in = 1; count_in = 5; parity_in = 0; tick(3);
    valid_in = 0; tick();
    chk("par_err_held", parity_err, 1);
    chk("par_last_upd", last_count, 5);
    rst = 1; #1;
    chk("par_err_clr", parity_err, 0);
    tick(); rst = 0;
    // Reset during the completion window
    clr_logs();
    req = 4'b0010; tick(6);
    chk("mid_busy", busy, 1);
    rst = 1; #1;
    chk("mid_reset_outs", {cnt_rst, busy, grant_id, ack, err, parity_err, last_count}, 64'd0);
    req = 4'b1111; tick(); rst = 0; tick();
    chk("mid_ptr_zero", grant_id, 0);
    chk("mid_new_pulse", cnt_rst, 1);
    chk("mid_no_done", nack + nerr, 0);
    req = '0;
    do_reset();
    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      slow = ((k / 300) % 2) == 1;
      for (int b = 0; b < N; b++)
        if (req[b] && (ack[b] || err[b] || $urandom_range(0, 199) == 0)) req[b] = 0;
        else if (!req[b] && $urandom_range(0, 9) == 0) req[b] = 1;
      valid_in = $urandom_range(0, 3) == 0;
      count_in = (!slow && $urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : ($urandom | 32'h10);
      parity_in = ($urandom_range(0, 49) == 0) ? ~^count_in : ^count_in;
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 0; valid_in = 0; req = '0; tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
